// File: rtl/ab_game_pkg.sv
// ab_game_pkg: shared types and constants for the 1A2B game engine.
//   state_t      FSM state encoding (exported on out_state)
//   DIGIT_W      bits per BCD digit
//   DIGIT_CNT    digits per secret/guess word
//   WORD_W       packed word width, digit0 in the top nibble
//   INVALID_CODE count value reported for a rejected guess (GUESS_CHECK_EN builds)
//   digit_of()   extracts digit idx (0 = most significant nibble) from a word
package ab_game_pkg;

   localparam int DIGIT_W   = 4;
   localparam int DIGIT_CNT = 4;
   localparam int WORD_W    = DIGIT_W * DIGIT_CNT;
   localparam int CNT_W     = 3;

   localparam logic [CNT_W-1:0] INVALID_CODE = 3'd7;
   localparam logic [CNT_W-1:0] WIN_COUNT    = 3'(DIGIT_CNT);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SCORE = 3'd3,
      ST_WIN   = 3'd4
   } state_t;

   function automatic logic [DIGIT_W-1:0] digit_of(input logic [WORD_W-1:0] word,
                                                  input int idx);
      logic [WORD_W-1:0] shifted;
      shifted = word >> (DIGIT_W * (DIGIT_CNT - 1 - idx));
      return shifted[DIGIT_W-1:0];
   endfunction

endpackage

// File: rtl/ab_scorer.sv
// ab_scorer: combinational 1A2B scoring of a guess word against a secret word.
//   secret  in  16  secret digits, digit0 in [15:12]
//   guess   in  16  guess digits, paired position-wise with secret
//   a_num   out 3   digits matching at the same position
//   b_num   out 3   non-matching positions whose digit occurs elsewhere in secret
//   invalid out 1   (GUESS_CHECK_EN only) guess has a digit >9 or a repeated digit
// Optional feature macro: GUESS_CHECK_EN.
module ab_scorer
   import ab_game_pkg::*;
(
   input  logic [WORD_W-1:0] secret,
   input  logic [WORD_W-1:0] guess,
   output logic [CNT_W-1:0]  a_num,
   output logic [CNT_W-1:0]  b_num
`ifdef GUESS_CHECK_EN
   ,
   output logic              invalid
`endif
);

   logic [DIGIT_CNT-1:0] bull;
   logic [DIGIT_CNT-1:0] cow_hit;

   always_comb begin
      bull    = '0;
      cow_hit = '0;
      a_num   = '0;
      b_num   = '0;
      for (int i = 0; i < DIGIT_CNT; i++) begin
         bull[i] = (digit_of(guess, i) == digit_of(secret, i));
         for (int j = 0; j < DIGIT_CNT; j++) begin
            if ((j != i) && (digit_of(guess, i) == digit_of(secret, j)))
               cow_hit[i] = 1'b1;
         end
      end
      // A position that is already a bull never also counts as a cow.
      for (int i = 0; i < DIGIT_CNT; i++) begin
         if (bull[i])
            a_num = a_num + 3'd1;
         else if (cow_hit[i])
            b_num = b_num + 3'd1;
      end
   end

`ifdef GUESS_CHECK_EN
   always_comb begin
      invalid = 1'b0;
      for (int i = 0; i < DIGIT_CNT; i++) begin
         if (digit_of(guess, i) > 4'd9)
            invalid = 1'b1;
         for (int j = i + 1; j < DIGIT_CNT; j++) begin
            if (digit_of(guess, i) == digit_of(guess, j))
               invalid = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/ab_game_core.sv
// ab_game_core: 1A2B (Bulls & Cows) game engine.
//   in_clka      in  1  clock, all state on rising edge
//   in_restart   in  1  asynchronous active-high reset
//   in_loadtest  in  1  start/restart a round with SECRET
//   in_enter     in  1  arm guess entry (guess taken when it drops)
//   in_ans0..3   in  4  guess digits, ans0 pairs with secret digit0
//   out_Anum     out 3  A count
//   out_Bnum     out 3  B count
//   out_state    out 3  state register
//   out_valid    out 1  counts hold a scored guess
// Optional feature macro: GUESS_CHECK_EN (reject malformed guesses with 7/7).
//
// state | meaning
// IDLE  | after reset, waiting for in_loadtest
// LOAD  | secret loaded, waiting for in_enter
// WAIT  | entry armed, guess taken when in_enter drops
// SCORE | guess resampled every cycle, counts one cycle behind
// WIN   | 4A scored, outputs frozen until in_loadtest
module ab_game_core
   import ab_game_pkg::*;
#(
   parameter logic [WORD_W-1:0] SECRET = 16'h2345
) (
   input  logic               in_clka,
   input  logic               in_restart,
   input  logic               in_loadtest,
   input  logic               in_enter,
   input  logic [DIGIT_W-1:0] in_ans0,
   input  logic [DIGIT_W-1:0] in_ans1,
   input  logic [DIGIT_W-1:0] in_ans2,
   input  logic [DIGIT_W-1:0] in_ans3,
   output logic [CNT_W-1:0]   out_Anum,
   output logic [CNT_W-1:0]   out_Bnum,
   output logic [2:0]         out_state,
   output logic               out_valid
);

   state_t              state;
   state_t              state_next;
   logic [WORD_W-1:0]   secret;
   logic [WORD_W-1:0]   guess;
   logic                load_secret;
   logic                capture_guess;
   logic                update_score;
   logic                clear_score;
   logic [CNT_W-1:0]    a_score;
   logic [CNT_W-1:0]    b_score;
   logic                score_invalid;
   logic [CNT_W-1:0]    a_next;
   logic [CNT_W-1:0]    b_next;

   ab_scorer u_scorer (
      .secret  (secret),
      .guess   (guess),
      .a_num   (a_score),
      .b_num   (b_score)
`ifdef GUESS_CHECK_EN
      ,
      .invalid (score_invalid)
`endif
   );

`ifndef GUESS_CHECK_EN
   assign score_invalid = 1'b0;
`endif

   assign a_next = score_invalid ? INVALID_CODE : a_score;
   assign b_next = score_invalid ? INVALID_CODE : b_score;

   always_ff @(posedge in_clka or posedge in_restart) begin
      if (in_restart)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next    = state;
      load_secret   = 1'b0;
      capture_guess = 1'b0;
      update_score  = 1'b0;
      clear_score   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (in_loadtest) begin
               state_next  = ST_LOAD;
               load_secret = 1'b1;
            end
         end
         ST_LOAD: begin
            if (in_loadtest)
               load_secret = 1'b1;
            else if (in_enter)
               state_next = ST_WAIT;
         end
         ST_WAIT: begin
            // in_loadtest is deliberately not looked at while entry is armed.
            if (!in_enter) begin
               state_next    = ST_SCORE;
               capture_guess = 1'b1;
            end
         end
         ST_SCORE: begin
            if (in_loadtest) begin
               state_next  = ST_LOAD;
               load_secret = 1'b1;
               clear_score = 1'b1;
            end else begin
               capture_guess = 1'b1;
               update_score  = 1'b1;
               if (!score_invalid && (a_score == WIN_COUNT))
                  state_next = ST_WIN;
            end
         end
         ST_WIN: begin
            if (in_loadtest) begin
               state_next  = ST_LOAD;
               load_secret = 1'b1;
               clear_score = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_clka or posedge in_restart) begin
      if (in_restart) begin
         secret    <= '0;
         guess     <= '0;
         out_Anum  <= '0;
         out_Bnum  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (load_secret)
            secret <= SECRET;
         if (capture_guess)
            guess <= {in_ans0, in_ans1, in_ans2, in_ans3};
         if (clear_score) begin
            out_Anum  <= '0;
            out_Bnum  <= '0;
            out_valid <= 1'b0;
         end else if (update_score) begin
            out_Anum  <= a_next;
            out_Bnum  <= b_next;
            out_valid <= 1'b1;
         end
      end
   end

   assign out_state = state;

endmodule

// File: tb/tb_ab_game_core.sv
module tb_ab_game_core;

   localparam logic [15:0] TB_SECRET = 16'h2345;

   logic       in_clka;
   logic       in_restart;
   logic       in_loadtest;
   logic       in_enter;
   logic [3:0] in_ans0, in_ans1, in_ans2, in_ans3;
   logic [2:0] out_Anum, out_Bnum, out_state;
   logic       out_valid;

   int checks = 0;
   int errors = 0;

   ab_game_core #(.SECRET(TB_SECRET)) dut (
      .in_clka     (in_clka),
      .in_restart  (in_restart),
      .in_loadtest (in_loadtest),
      .in_enter    (in_enter),
      .in_ans0     (in_ans0),
      .in_ans1     (in_ans1),
      .in_ans2     (in_ans2),
      .in_ans3     (in_ans3),
      .out_Anum    (out_Anum),
      .out_Bnum    (out_Bnum),
      .out_state   (out_state),
      .out_valid   (out_valid)
   );

   initial begin
      in_clka = 1'b0;
      forever #5 in_clka = ~in_clka;
   end

   // Reference scoring: bulls are positional matches; cows are the remaining
   // guess positions whose digit appears anywhere in the secret.
   function automatic logic [5:0] model_score(input logic [15:0] g);
      int a = 0;
      int b = 0;
      logic [3:0] gd[4];
      logic [3:0] sd[4];
      bit bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         gd[i] = 4'(g >> (12 - 4 * i));
         sd[i] = 4'(TB_SECRET >> (12 - 4 * i));
      end
      for (int i = 0; i < 4; i++) begin
         bit found = 1'b0;
         for (int j = 0; j < 4; j++)
            if (sd[j] == gd[i]) found = 1'b1;
         if (gd[i] == sd[i]) a++;
         else if (found) b++;
      end
`ifdef GUESS_CHECK_EN
      for (int i = 0; i < 4; i++) begin
         if (gd[i] > 4'd9) bad = 1'b1;
         for (int j = 0; j < 4; j++)
            if (i != j && gd[i] == gd[j]) bad = 1'b1;
      end
`endif
      if (bad) return {3'd7, 3'd7};
      return {3'(a), 3'(b)};
   endfunction

   task automatic step();
      @(posedge in_clka);
      #1;
   endtask

   task automatic drive_guess(input logic [15:0] g);
      in_ans0 = g[15:12];
      in_ans1 = g[11:8];
      in_ans2 = g[7:4];
      in_ans3 = g[3:0];
   endtask

   // From IDLE, SCORE or WIN: leaves the DUT in WAIT with enter still high.
   task automatic begin_round();
      in_loadtest = 1'b1;
      in_enter    = 1'b0;
      step();
      in_loadtest = 1'b0;
      in_enter    = 1'b1;
      step();
   endtask

   task automatic test_reset();
      in_restart = 1'b1;
      repeat (3) step();
      checks++;
      if (out_state !== 3'd0 || out_valid !== 1'b0 || out_Anum !== 3'd0 || out_Bnum !== 3'd0) begin
         errors++;
         $display("FAIL reset_outputs got state=%0d valid=%0d A=%0d B=%0d exp 0 0 0 0",
                  out_state, out_valid, out_Anum, out_Bnum);
      end
      in_restart = 1'b0;
      repeat (2) step();
      checks++;
      if (out_state !== 3'd0) begin
         errors++;
         $display("FAIL reset_release_idle got state=%0d exp 0", out_state);
      end
   endtask

   task automatic test_win();
      begin_round();
      checks++;
      if (out_state !== 3'd2) begin
         errors++;
         $display("FAIL win_wait_state got %0d exp 2", out_state);
      end
      in_enter = 1'b0;
      drive_guess(16'h2345);
      step();
      checks++;
      if (out_state !== 3'd3 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL win_first_score got state=%0d valid=%0d exp 3 0", out_state, out_valid);
      end
      step();
      checks++;
      if (out_Anum !== 3'd4 || out_Bnum !== 3'd0 || out_valid !== 1'b1 || out_state !== 3'd4) begin
         errors++;
         $display("FAIL win_result got A=%0d B=%0d valid=%0d state=%0d exp 4 0 1 4",
                  out_Anum, out_Bnum, out_valid, out_state);
      end
      drive_guess(16'h1234);
      repeat (3) step();
      checks++;
      if (out_Anum !== 3'd4 || out_Bnum !== 3'd0 || out_valid !== 1'b1 || out_state !== 3'd4) begin
         errors++;
         $display("FAIL win_frozen got A=%0d B=%0d valid=%0d state=%0d exp 4 0 1 4",
                  out_Anum, out_Bnum, out_valid, out_state);
      end
   endtask

   task automatic test_cows();
      in_loadtest = 1'b1;
      step();
      checks++;
      if (out_state !== 3'd1 || out_valid !== 1'b0 || out_Anum !== 3'd0 || out_Bnum !== 3'd0) begin
         errors++;
         $display("FAIL reload_clear got state=%0d valid=%0d A=%0d B=%0d exp 1 0 0 0",
                  out_state, out_valid, out_Anum, out_Bnum);
      end
      in_loadtest = 1'b0;
      in_enter    = 1'b1;
      step();
      in_enter = 1'b0;
      drive_guess(16'h5432);
      repeat (2) step();
      checks++;
      if (out_Anum !== 3'd0 || out_Bnum !== 3'd4 || out_state !== 3'd3 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL cows_5432 got A=%0d B=%0d state=%0d valid=%0d exp 0 4 3 1",
                  out_Anum, out_Bnum, out_state, out_valid);
      end
   endtask

   task automatic test_pipeline();
      begin_round();
      in_enter = 1'b0;
      drive_guess(16'h5423);
      repeat (2) step();
      checks++;
      if (out_Anum !== 3'd0 || out_Bnum !== 3'd4) begin
         errors++;
         $display("FAIL pipe_5423 got A=%0d B=%0d exp 0 4", out_Anum, out_Bnum);
      end
      drive_guess(16'h5428);
      step();
      checks++;
      if (out_Anum !== 3'd0 || out_Bnum !== 3'd4) begin
         errors++;
         $display("FAIL pipe_latency1 got A=%0d B=%0d exp 0 4", out_Anum, out_Bnum);
      end
      step();
      checks++;
      if (out_Anum !== 3'd0 || out_Bnum !== 3'd3 || out_state !== 3'd3) begin
         errors++;
         $display("FAIL pipe_5428 got A=%0d B=%0d state=%0d exp 0 3 3", out_Anum, out_Bnum, out_state);
      end
   endtask

   task automatic test_restart_mid_score();
      begin_round();
      in_enter = 1'b0;
      drive_guess(16'h2354);
      repeat (2) step();
      checks++;
      if (out_Anum !== 3'd2 || out_Bnum !== 3'd2 || out_state !== 3'd3) begin
         errors++;
         $display("FAIL pre_restart got A=%0d B=%0d state=%0d exp 2 2 3", out_Anum, out_Bnum, out_state);
      end
      #2;
      in_restart = 1'b1;
      #1;
      checks++;
      if (out_state !== 3'd0 || out_valid !== 1'b0 || out_Anum !== 3'd0 || out_Bnum !== 3'd0) begin
         errors++;
         $display("FAIL async_restart got state=%0d valid=%0d A=%0d B=%0d exp 0 0 0 0",
                  out_state, out_valid, out_Anum, out_Bnum);
      end
      step();
      in_restart = 1'b0;
      step();
      checks++;
      if (out_state !== 3'd0) begin
         errors++;
         $display("FAIL restart_idle got state=%0d exp 0", out_state);
      end
   endtask

   task automatic test_priority();
      in_loadtest = 1'b1;
      in_enter    = 1'b1;
      repeat (2) step();
      checks++;
      if (out_state !== 3'd1) begin
         errors++;
         $display("FAIL load_priority got state=%0d exp 1", out_state);
      end
      in_loadtest = 1'b0;
      step();
      in_loadtest = 1'b1;
      step();
      checks++;
      if (out_state !== 3'd2) begin
         errors++;
         $display("FAIL wait_ignores_load got state=%0d exp 2", out_state);
      end
      in_enter = 1'b0;
      drive_guess(16'h3245);
      step();
      checks++;
      if (out_state !== 3'd3) begin
         errors++;
         $display("FAIL wait_to_score got state=%0d exp 3", out_state);
      end
      in_loadtest = 1'b0;
      step();
      checks++;
      if (out_Anum !== 3'd2 || out_Bnum !== 3'd2) begin
         errors++;
         $display("FAIL priority_score got A=%0d B=%0d exp 2 2", out_Anum, out_Bnum);
      end
   endtask

   task automatic test_malformed();
      logic [2:0] ea, eb;
      begin_round();
      in_enter = 1'b0;
      drive_guess(16'h1123);
`ifdef GUESS_CHECK_EN
      ea = 3'd7; eb = 3'd7;
`else
      ea = 3'd0; eb = 3'd2;
`endif
      repeat (2) step();
      checks++;
      if (out_Anum !== ea || out_Bnum !== eb || out_valid !== 1'b1 || out_state !== 3'd3) begin
         errors++;
         $display("FAIL repeat_1123 got A=%0d B=%0d valid=%0d state=%0d exp %0d %0d 1 3",
                  out_Anum, out_Bnum, out_valid, out_state, ea, eb);
      end
      drive_guess(16'hA234);
`ifdef GUESS_CHECK_EN
      ea = 3'd7; eb = 3'd7;
`else
      ea = 3'd0; eb = 3'd3;
`endif
      repeat (2) step();
      checks++;
      if (out_Anum !== ea || out_Bnum !== eb || out_state !== 3'd3) begin
         errors++;
         $display("FAIL digit_A234 got A=%0d B=%0d state=%0d exp %0d %0d 3",
                  out_Anum, out_Bnum, out_state, ea, eb);
      end
   endtask

   task automatic test_random();
      logic [15:0] prev, cur;
      logic [5:0]  exp_ab;
      bit          won;
      begin_round();
      in_enter = 1'b0;
      prev = 16'h0189;
      drive_guess(prev);
      step();
      won = 1'b0;
      exp_ab = '0;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 7) == 0)
            cur = TB_SECRET;
         else
            for (int d = 0; d < 4; d++)
               cur[d*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
         drive_guess(cur);
         step();
         if (!won) begin
            exp_ab = model_score(prev);
            if (exp_ab == {3'd4, 3'd0}) won = 1'b1;
         end
         checks++;
         if (out_Anum !== exp_ab[5:3] || out_Bnum !== exp_ab[2:0] || out_valid !== 1'b1 ||
             out_state !== (won ? 3'd4 : 3'd3)) begin
            errors++;
            $display("FAIL random_%0d guess=%h got A=%0d B=%0d valid=%0d state=%0d exp %0d %0d 1 %0d",
                     k, prev, out_Anum, out_Bnum, out_valid, out_state, exp_ab[5:3], exp_ab[2:0],
                     won ? 4 : 3);
         end
         prev = cur;
         if (won) begin
            begin_round();
            in_enter = 1'b0;
            drive_guess(prev);
            step();
            won = 1'b0;
         end
      end
   endtask

   initial begin
      in_restart  = 1'b1;
      in_loadtest = 1'b0;
      in_enter    = 1'b0;
      drive_guess(16'h0000);
      test_reset();
      test_win();
      test_cows();
      test_pipeline();
      test_restart_mid_score();
      test_priority();
      test_malformed();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
